// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the round-robin packet arbiter.
package pkt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam int BYTE_W = 8;

    // Index width for n requesters; a 2-way arbiter still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req at or above ptr, wrapping past N-1.
// Combinational; no backpressure.
module rr_pick
    import pkt_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [idx_w(N)-1:0]   winner,
    output logic                  any_req
);

    localparam int IDX_W = idx_w(N);

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_req && req[(int'(ptr) + i) % N]) begin
                any_req = 1'b1;
                winner  = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Round-robin arbiter forwarding one whole packet at a time from N sources; 1-cycle registered data path.
// No downstream backpressure; sources are paced by the grant pulse. Watchdog abort under PKT_ARB_TIMEOUT_EN.
module pkt_rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int N           = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N-1:0]          i_req,
    input  logic [BYTE_W*N-1:0]   i_len,
    input  logic [BYTE_W*N-1:0]   i_data,
    input  logic [N-1:0]          i_last,
    input  logic [N-1:0]          i_valid,
    output logic [N-1:0]          o_grant,
    output logic [BYTE_W-1:0]     o_post_len,
    output logic [BYTE_W-1:0]     o_post_data,
    output logic                  o_post_last,
    output logic                  o_post_valid,
    output logic [idx_w(N)-1:0]   o_src_id,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int IDX_W = idx_w(N);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [3:0]         gap_q;
    logic [BYTE_W-1:0]  sel_len, sel_data;
    logic               sel_valid, sel_qlast;
    logic               abort;

    rr_pick #(.N(N)) u_pick (
        .req     (i_req),
        .ptr     (ptr_q),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    assign sel_len   = i_len[BYTE_W*int'(o_src_id) +: BYTE_W];
    assign sel_data  = i_data[BYTE_W*int'(o_src_id) +: BYTE_W];
    assign sel_valid = i_valid[o_src_id];
    assign sel_qlast = sel_valid & i_last[o_src_id];

`ifdef PKT_ARB_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        timeout_q;

    assign abort     = (state_q == XFER) && !sel_qlast && (wd_q == 16'(TIMEOUT_CYC - 1));
    assign o_timeout = timeout_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= abort;
            if (state_q == GRANT)
                wd_q <= '0;
            else if (state_q == XFER)
                wd_q <= wd_q + 16'd1;
        end
    end
`else
    assign abort = 1'b0;
    // Limit only matters with the watchdog built in; the term folds to zero.
    assign o_timeout = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = GRANT;
            GRANT:   state_d = XFER;
            XFER:    if (sel_qlast || abort) state_d = GAP;
            GAP:     if (gap_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q        <= '0;
            gap_q        <= '0;
            o_src_id     <= '0;
            o_post_len   <= '0;
            o_post_data  <= '0;
            o_post_last  <= 1'b0;
            o_post_valid <= 1'b0;
        end else begin
            o_post_valid <= 1'b0;
            o_post_last  <= 1'b0;
            if (state_q == IDLE && pick_any)
                o_src_id <= pick_idx;
            if (state_q == XFER) begin
                o_post_len   <= sel_len;
                o_post_data  <= sel_data;
                o_post_valid <= sel_valid;
                o_post_last  <= sel_qlast;
            end
            // Rotate past the winner whether its packet finished or was aborted.
            if (state_q == XFER && state_d == GAP) begin
                ptr_q <= (o_src_id == IDX_W'(N - 1)) ? '0 : o_src_id + 1'b1;
                gap_q <= 4'(GAP_CYC - 1);
            end else if (state_q == GAP && gap_q != '0) begin
                gap_q <= gap_q - 4'd1;
            end
        end
    end

    assign o_grant = (state_q == GRANT) ? (N'(1) << o_src_id) : '0;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter (N=4, GAP_CYC=2, TIMEOUT_CYC=16).
module tb_pkt_rr_arbiter;

    localparam int N           = 4;
    localparam int GAP_CYC     = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int SPACING3    = 1 + 3 + GAP_CYC + 1;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req, i_last, i_valid;
    logic [8*N-1:0] i_len, i_data;
    logic [N-1:0]   o_grant;
    logic [7:0]     o_post_len, o_post_data;
    logic           o_post_last, o_post_valid, o_busy, o_timeout;
    logic [1:0]     o_src_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gcyc = 0;
    int prev_gcyc = 0;
    int extra;
    int waited;
    int seen_last;

    pkt_rr_arbiter #(.N(N), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_len        (i_len),
        .i_data       (i_data),
        .i_last       (i_last),
        .i_valid      (i_valid),
        .o_grant      (o_grant),
        .o_post_len   (o_post_len),
        .o_post_data  (o_post_data),
        .o_post_last  (o_post_last),
        .o_post_valid (o_post_valid),
        .o_src_id     (o_src_id),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_grant"},  32'(o_grant), 0);
        check({tag, "_len"},    32'(o_post_len), 0);
        check({tag, "_data"},   32'(o_post_data), 0);
        check({tag, "_last"},   32'(o_post_last), 0);
        check({tag, "_valid"},  32'(o_post_valid), 0);
        check({tag, "_src"},    32'(o_src_id), 0);
        check({tag, "_busy"},   32'(o_busy), 0);
        check({tag, "_tmo"},    32'(o_timeout), 0);
    endtask

    task automatic wait_grant(input string tag, input int src, input bit drop);
        int w = 0;
        @(negedge i_clk);
        while (o_grant == '0 && w < 40) begin
            @(negedge i_clk);
            w++;
        end
        check({tag, "_grant_seen"}, 32'(w < 40), 1);
        check({tag, "_grant"}, 32'(o_grant), 32'(1) << src);
        check({tag, "_src_id"}, 32'(o_src_id), 32'(src));
        prev_gcyc = gcyc;
        gcyc = cyc;
        if (drop) i_req[src] = 1'b0;
    endtask

    // Source behaviour after a grant: one byte per cycle; optional stray source drives junk alongside.
    task automatic stream(input string tag, input int src, input int n, input logic [7:0] base,
                          input bit with_last, input int stray);
        for (int b = 0; b <= n; b++) begin
            @(posedge i_clk); #1;
            if (b > 0) begin
                check({tag, "_valid"}, 32'(o_post_valid), 1);
                check({tag, "_data"},  32'(o_post_data), 32'(base + 8'(b - 1)));
                check({tag, "_last"},  32'(o_post_last), 32'(with_last && b == n));
                check({tag, "_len"},   32'(o_post_len), 32'(n));
            end
            if (b < n) begin
                i_len[8*src +: 8]  = 8'(n);
                i_data[8*src +: 8] = base + 8'(b);
                i_valid[src]       = 1'b1;
                i_last[src]        = with_last && (b == n - 1);
                if (stray >= 0) begin
                    i_valid[stray]       = 1'b1;
                    i_last[stray]        = 1'b1;
                    i_data[8*stray +: 8] = 8'hEE;
                    i_len[8*stray +: 8]  = 8'hEE;
                end
            end else begin
                i_valid = '0;
                i_last  = '0;
            end
        end
    endtask

    task automatic run_pkt(input string tag, input int src, input int n, input logic [7:0] base,
                           input bit drop, input int stray);
        wait_grant(tag, src, drop);
        stream(tag, src, n, base, 1'b1, stray);
        @(posedge i_clk); #1;
        check({tag, "_gap_valid"}, 32'(o_post_valid), 0);
        check({tag, "_gap_busy"},  32'(o_busy), 1);
    endtask

    initial begin
        i_rst = 1'b1; i_req = '0; i_len = '0; i_data = '0; i_last = '0; i_valid = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_zero_outs("reset");
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // All four requesting continuously: strict rotation and fixed grant spacing.
        i_req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            run_pkt("all", k % 4, 3, 8'(8'h20 + 16 * k), 1'b0, -1);
            if (k > 0) check("all_spacing", 32'(gcyc - prev_gcyc), SPACING3);
        end
        i_req = '0;

        // Single source 2, five bytes 0x11..0x15, granted exactly once.
        @(posedge i_clk); #1;
        i_req = 4'b0100;
        run_pkt("single", 2, 5, 8'h11, 1'b1, -1);
        extra = 0;
        repeat (8) begin
            @(negedge i_clk);
            if (o_grant != '0) extra++;
        end
        check("single_once", 32'(extra), 0);
        check("single_idle_busy", 32'(o_busy), 0);

        // Move ptr to 2 via source 1, then 1 and 3 request: 3 first, 1's junk must not leak.
        i_req = 4'b0010;
        run_pkt("p1", 1, 2, 8'h40, 1'b1, -1);
        i_req = 4'b1010;
        run_pkt("s3", 3, 3, 8'h50, 1'b1, 1);
        run_pkt("s1", 1, 2, 8'h60, 1'b1, -1);
        i_req = '0;

        // Reset on the second byte of a four-byte packet from source 3 (ptr is 2 here).
        @(posedge i_clk); #1;
        i_req = 4'b1000;
        wait_grant("rstpkt", 3, 1'b1);
        @(posedge i_clk); #1;
        i_len[31:24] = 8'd4; i_data[31:24] = 8'h90; i_valid[3] = 1'b1;
        @(posedge i_clk); #1;
        i_data[31:24] = 8'h91;
        i_rst = 1'b1;
        #1;
        check_zero_outs("midrst");
        @(negedge i_clk);
        i_rst = 1'b0; i_valid = '0; i_last = '0;
        @(posedge i_clk); #1;
        i_req = 4'hF;
        run_pkt("postrst", 0, 1, 8'hA0, 1'b1, -1);
        i_req = '0;

        // Granted source sends two bytes and never a last (ptr is 1, so 2 wins).
        @(posedge i_clk); #1;
        i_req = 4'b0100;
        wait_grant("wd", 2, 1'b1);
        stream("wd", 2, 2, 8'h80, 1'b0, -1);
`ifdef PKT_ARB_TIMEOUT_EN
        seen_last = 0;
        waited = 0;
        while (o_timeout !== 1'b1 && waited < 40) begin
            @(negedge i_clk);
            if (o_post_last) seen_last = 1;
            waited++;
        end
        // Pulse lands in the first cycle after the 16 counted XFER cycles.
        check("wd_pulse_cyc", 32'(cyc - gcyc), 17);
        check("wd_no_last", 32'(seen_last), 0);
        @(negedge i_clk);
        check("wd_pulse_width", 32'(o_timeout), 0);
        i_req = 4'hF;
        run_pkt("wd_next", 3, 1, 8'hB0, 1'b1, -1);
        i_req = '0;
`else
        repeat (30) @(posedge i_clk);
        #1;
        check("wd_stuck_busy", 32'(o_busy), 1);
        check("wd_stuck_tmo", 32'(o_timeout), 0);
        check("wd_stuck_valid", 32'(o_post_valid), 0);
        check("wd_stuck_src", 32'(o_src_id), 2);
        i_data[23:16] = 8'h82; i_valid[2] = 1'b1; i_last[2] = 1'b1;
        @(posedge i_clk); #1;
        i_valid = '0; i_last = '0;
        check("wd_end_valid", 32'(o_post_valid), 1);
        check("wd_end_last", 32'(o_post_last), 1);
        check("wd_end_data", 32'(o_post_data), 32'h82);
        @(posedge i_clk); #1;
        check("wd_end_gap_valid", 32'(o_post_valid), 0);
        check("wd_end_gap_busy", 32'(o_busy), 1);
`endif
        repeat (4) @(posedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
